// File: rtl/expr_pipe_pkg.sv
// Shared opcode encoding and result-width helper for the expression lane pipeline.
package expr_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ASHR = 4'd8,
    OP_LT   = 4'd9,
    OP_LE   = 4'd10,
    OP_EQ   = 4'd11,
    OP_LAND = 4'd12,
    OP_RXOR = 4'd13,
    OP_DIV  = 4'd14,
    OP_MOD  = 4'd15
  } op_e;

  // One guard bit above the operand width holds the carry of add/sub.
  function automatic int res_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/expr_lane.sv
// Combinational single-lane evaluator on pre-extended operands.
// EXPR_PIPE_DIV_EN enables the DIV/MOD datapath; otherwise both flag an error.
module expr_lane
  import expr_pipe_pkg::*;
#(
  parameter int W = 6,
  parameter int R = res_w(W)
) (
  input  logic [R-1:0] a_i,
  input  logic [R-1:0] b_i,
  input  logic         sgn_i,
  input  op_e          op_i,
  output logic [R-1:0] res_o,
  output logic         err_o
);

  logic signed [R-1:0] a_s;
  logic signed [R-1:0] b_s;
  logic [W-1:0]        amt;
  logic                lt;
  logic                le;

  assign a_s = a_i;
  assign b_s = b_i;
  // Shift amount is the raw operand, never its sign-extended form.
  assign amt = b_i[W-1:0];
  assign lt  = sgn_i ? (a_s < b_s)  : (a_i < b_i);
  assign le  = sgn_i ? (a_s <= b_s) : (a_i <= b_i);

  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_XNOR: res_o = ~(a_i ^ b_i);
      OP_SHL:  res_o = a_i << amt;
      OP_SHR:  res_o = a_i >> amt;
      OP_ASHR: begin
        if (sgn_i) res_o = a_s >>> amt;
        else       res_o = a_i >> amt;
      end
      OP_LT:   res_o = {{(R-1){1'b0}}, lt};
      OP_LE:   res_o = {{(R-1){1'b0}}, le};
      OP_EQ:   res_o = {{(R-1){1'b0}}, a_i == b_i};
      OP_LAND: res_o = {{(R-1){1'b0}}, (|a_i) && (|b_i)};
      OP_RXOR: res_o = {{(R-1){1'b0}}, ^a_i[W-1:0]};
`ifdef EXPR_PIPE_DIV_EN
      OP_DIV, OP_MOD: begin
        if (b_i == '0) begin
          err_o = 1'b1;
        end else if (sgn_i) begin
          res_o = (op_i == OP_DIV) ? a_s / b_s : a_s % b_s;
        end else begin
          res_o = (op_i == OP_DIV) ? a_i / b_i : a_i % b_i;
        end
      end
`else
      OP_DIV, OP_MOD: err_o = 1'b1;
`endif
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/expr_lane_pipe.sv
// Two-stage valid/ready pipeline evaluating LANES expressions per transaction,
// with a running XOR signature of consumed results. DIV/MOD gated by EXPR_PIPE_DIV_EN.
module expr_lane_pipe
  import expr_pipe_pkg::*;
#(
  parameter int W     = 6,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*W-1:0]       in_a,
  input  logic [LANES*W-1:0]       in_b,
  input  logic [LANES-1:0]         in_sa,
  input  logic [LANES-1:0]         in_sb,
  input  logic [LANES*4-1:0]       in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*(W+1)-1:0]   out_data,
  output logic [LANES-1:0]         out_err,
  input  logic                     sig_clr,
  output logic [LANES*(W+1)-1:0]   sig
);

  localparam int R = res_w(W);

  logic                 s1_valid_q, s1_valid_d;
  logic [LANES*R-1:0]   a_q, b_q;
  logic [LANES-1:0]     sgn_q;
  logic [LANES*4-1:0]   op_q;
  logic                 out_valid_q;
  logic [LANES*R-1:0]   data_q;
  logic [LANES-1:0]     err_q;
  logic [LANES*R-1:0]   sig_q, sig_d;

  logic                 s2_load;
  logic                 in_fire;
  logic                 out_fire;
  logic [LANES*R-1:0]   a_x, b_x, res;
  logic [LANES-1:0]     ctx, err;

  assign s2_load  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    ctx = '0;
    a_x = '0;
    b_x = '0;
    for (int i = 0; i < LANES; i++) begin
      ctx[i]        = in_sa[i] & in_sb[i];
      a_x[i*R +: R] = {ctx[i] & in_a[i*W + W-1], in_a[i*W +: W]};
      b_x[i*R +: R] = {ctx[i] & in_b[i*W + W-1], in_b[i*W +: W]};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire)      s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
  end

  always_comb begin
    sig_d = sig_q;
    if (sig_clr)       sig_d = '0;
    else if (out_fire) sig_d = sig_q ^ data_q;
  end

  // S1: extended operands, context flags and opcodes
  always_ff @(posedge clk) begin
    if (!rst_n) s1_valid_q <= 1'b0;
    else        s1_valid_q <= s1_valid_d;
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      a_q   <= a_x;
      b_q   <= b_x;
      sgn_q <= ctx;
      op_q  <= in_op;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    expr_lane #(.W(W)) u_lane (
      .a_i   (a_q[g*R +: R]),
      .b_i   (b_q[g*R +: R]),
      .sgn_i (sgn_q[g]),
      .op_i  (op_e'(op_q[g*4 +: 4])),
      .res_o (res[g*R +: R]),
      .err_o (err[g])
    );
  end

  // S2: lane results, error flags and output valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q <= res;
        err_q  <= err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign sig       = sig_q;

endmodule

// File: tb/tb_expr_lane_pipe.sv
// Scoreboard bench for expr_lane_pipe: directed vectors, backpressure, random traffic, signature, reset.
module tb_expr_lane_pipe;

  localparam int W     = 6;
  localparam int LANES = 4;
  localparam int R     = W + 1;
  localparam int LW    = LANES * R;
  localparam int IW    = LANES * W;

`ifdef EXPR_PIPE_DIV_EN
  localparam logic [6:0] DIVQ = 7'd3;
  localparam logic [6:0] MODR = 7'd1;
  localparam logic       DIVE = 1'b0;
`else
  localparam logic [6:0] DIVQ = 7'd0;
  localparam logic [6:0] MODR = 7'd0;
  localparam logic       DIVE = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW-1:0]     in_a = '0, in_b = '0;
  logic [LANES-1:0]  in_sa = '0, in_sb = '0;
  logic [LANES*4-1:0] in_op = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LW-1:0]     out_data;
  logic [LANES-1:0]  out_err;
  logic              sig_clr = 1'b0;
  logic [LW-1:0]     sig;

  expr_lane_pipe #(.W(W), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sa(in_sa), .in_sb(in_sb), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .sig_clr(sig_clr), .sig(sig)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0] e;
    logic [LW-1:0]    d;
  } exp_t;

  exp_t          sb[$];
  exp_t          nxt_exp = '0;
  exp_t          t_exp = '0;
  logic [LW-1:0] sig_exp = '0;
  bit            t_acc, t_got, t_have, t_inrdy;
  logic [LW-1:0] t_data;
  logic [LANES-1:0] t_err;
  int            total = 0;
  int            bad = 0;

  function automatic logic [7:0] model_lane(input logic [5:0] a, input logic [5:0] b,
                                            input bit sa, input bit sb_f, input logic [3:0] op);
    int av, bv, amt, r;
    bit sgn, e;
    sgn = sa && sb_f;
    av  = (sgn && a[5]) ? int'(a) - 64 : int'(a);
    bv  = (sgn && b[5]) ? int'(b) - 64 : int'(b);
    amt = int'(b);
    e   = 1'b0;
    r   = 0;
    case (op)
      4'd0:  r = av + bv;
      4'd1:  r = av - bv;
      4'd2:  r = av & bv;
      4'd3:  r = av | bv;
      4'd4:  r = av ^ bv;
      4'd5:  r = ~(av ^ bv);
      4'd6:  r = (amt >= 7) ? 0 : av << amt;
      4'd7:  r = (amt >= 7) ? 0 : (av & 127) >> amt;
      4'd8:  begin
        if (sgn) r = (amt >= 7) ? ((av < 0) ? -1 : 0) : av >>> amt;
        else     r = (amt >= 7) ? 0 : (av & 127) >> amt;
      end
      4'd9:  r = (av < bv) ? 1 : 0;
      4'd10: r = (av <= bv) ? 1 : 0;
      4'd11: r = (av == bv) ? 1 : 0;
      4'd12: r = (a != 0 && b != 0) ? 1 : 0;
      4'd13: r = $countones(a) % 2;
      default: begin
`ifdef EXPR_PIPE_DIV_EN
        if (bv == 0) e = 1'b1;
        else r = (op == 4'd14) ? av / bv : av % bv;
`else
        e = 1'b1;
`endif
      end
    endcase
    return {e, r[6:0]};
  endfunction

  function automatic exp_t model_txn(input logic [IW-1:0] a, input logic [IW-1:0] b,
                                     input logic [LANES-1:0] sa, input logic [LANES-1:0] sbf,
                                     input logic [LANES*4-1:0] op);
    exp_t x;
    logic [7:0] l;
    x = '0;
    for (int i = 0; i < LANES; i++) begin
      l = model_lane(a[i*W +: W], b[i*W +: W], sa[i], sbf[i], op[i*4 +: 4]);
      x.d[i*R +: R] = l[6:0];
      x.e[i] = l[7];
    end
    return x;
  endfunction

  task automatic set_txn(input logic [IW-1:0] a, input logic [IW-1:0] b, input logic [LANES-1:0] sa,
                         input logic [LANES-1:0] sbf, input logic [LANES*4-1:0] op);
    in_a = a; in_b = b; in_sa = sa; in_sb = sbf; in_op = op; in_valid = 1'b1;
    nxt_exp = model_txn(a, b, sa, sbf, op);
  endtask

  // One clock: sample handshakes just after the falling edge, update the scoreboard, advance.
  task automatic tick();
    #1;
    t_inrdy = in_ready;
    t_acc   = rst_n && in_valid && in_ready;
    t_got   = rst_n && out_valid && out_ready;
    t_data  = out_data;
    t_err   = out_err;
    t_have  = 1'b0;
    if (t_got && sb.size() > 0) begin
      t_exp  = sb.pop_front();
      t_have = 1'b1;
    end
    if (t_acc) sb.push_back(nxt_exp);
    if (sig_clr) sig_exp = '0;
    else if (t_got) sig_exp = sig_exp ^ (t_have ? t_exp.d : t_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (out_err !== '0) begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    total++; if (sig !== '0) begin bad++; $display("FAIL reset_sig: got %h want 0", sig); end
  endtask

  task automatic test_ops();
    int outs = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: begin
          set_txn({4{6'h3F}}, {4{6'h01}}, 4'b1101, 4'b0111, 16'h9900);
          nxt_exp = '{e: 4'b0000, d: {7'h00, 7'h01, 7'h40, 7'h00}};
        end
        1: begin
          set_txn({6'h0D, 6'h21, 6'h20, 6'h20}, {6'h04, 6'h07, 6'h02, 6'h02}, 4'b0001, 4'b0001, 16'hE688);
          nxt_exp = '{e: {DIVE, 3'b000}, d: {DIVQ, 7'h00, 7'h08, 7'h78}};
        end
        2: begin
          set_txn({6'h05, 6'h07, 6'h0D, 6'h0D}, {6'h00, 6'h00, 6'h00, 6'h04}, 4'b0000, 4'b0000, 16'hCDEF);
          nxt_exp = '{e: {2'b00, 1'b1, DIVE}, d: {7'h00, 7'h01, 7'h00, MODR}};
        end
        default: in_valid = 1'b0;
      endcase
      tick();
      if (t_got) begin
        outs++;
        total++;
        if (!t_have || t_data !== t_exp.d || t_err !== t_exp.e) begin
          bad++;
          $display("FAIL ops_out%0d: got %h/%b want %h/%b", outs, t_data, t_err, t_exp.d, t_exp.e);
        end
      end
    end
    total++; if (outs != 3) begin bad++; $display("FAIL ops_count: got %0d want 3", outs); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_txn({4{6'h01}}, {4{6'h02}}, 4'h0, 4'h0, 16'h0000);
    tick();
    total++; if (!t_acc) begin bad++; $display("FAIL bp_accept0: got 0 want 1"); end
    set_txn({4{6'h05}}, {4{6'h03}}, 4'hF, 4'hF, 16'h1111);
    tick();
    total++; if (!t_acc) begin bad++; $display("FAIL bp_accept1: got 0 want 1"); end
    set_txn({4{6'h09}}, {4{6'h06}}, 4'h0, 4'h0, 16'h4444);
    tick();
    total++; if (t_inrdy || t_acc) begin bad++; $display("FAIL bp_full: in_ready=%b want 0", t_inrdy); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      in_valid = 1'b0;
      total++;
      if (!t_got || !t_have || t_data !== t_exp.d || t_err !== t_exp.e) begin
        bad++;
        $display("FAIL bp_drain%0d: got v=%b %h/%b want %h/%b", k, t_got, t_data, t_err, t_exp.d, t_exp.e);
      end
    end
    tick();
    total++; if (t_got || sb.size() != 0) begin bad++; $display("FAIL bp_empty: got extra=%b pending=%0d want none", t_got, sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit hold = 1'b0;
    int outs = 0;
    logic [IW-1:0] ra, rb;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        ra = IW'($urandom);
        rb = IW'($urandom);
        if ($urandom_range(0, 1) == 1) rb = rb & {LANES{6'h07}};
        set_txn(ra, rb, LANES'($urandom), LANES'($urandom), 16'($urandom));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = (c > 300) || ($urandom_range(0, 2) != 0);
      if (c >= 380) in_valid = 1'b0;
      tick();
      hold = in_valid && !t_acc;
      if (t_got) begin
        outs++;
        total++;
        if (!t_have || t_data !== t_exp.d || t_err !== t_exp.e) begin
          bad++;
          $display("FAIL rand_out%0d: got %h/%b want %h/%b", outs, t_data, t_err, t_exp.d, t_exp.e);
        end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rand_drain: pending=%0d want 0", sb.size()); end
    total++; if (sig !== sig_exp) begin bad++; $display("FAIL rand_sig: got %h want %h", sig, sig_exp); end
  endtask

  task automatic test_signature();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    sig_clr   = 1'b1;
    tick();
    sig_clr = 1'b0;
    total++; if (sig !== '0) begin bad++; $display("FAIL sig_clear: got %h want 0", sig); end
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: set_txn({18'h0, 6'h11}, '0, 4'h0, 4'h0, 16'h3333);
        1: set_txn({18'h0, 6'h05}, '0, 4'h0, 4'h0, 16'h3333);
        2: set_txn({18'h0, 6'h03}, '0, 4'h0, 4'h0, 16'h3333);
        default: in_valid = 1'b0;
      endcase
      tick();
      if (t_got) begin
        total++;
        if (!t_have || t_data !== t_exp.d) begin bad++; $display("FAIL sig_out: got %h want %h", t_data, t_exp.d); end
      end
    end
    total++; if (sig !== LW'(7'h14)) begin bad++; $display("FAIL sig_two: got %h want %h", sig, LW'(7'h14)); end
    sig_clr = 1'b1;
    tick();
    sig_clr = 1'b0;
    total++; if (!t_got) begin bad++; $display("FAIL sig_third_hs: got no handshake want one"); end
    total++; if (sig !== '0) begin bad++; $display("FAIL sig_clr_hs: got %h want 0", sig); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    set_txn({4{6'h0A}}, {4{6'h01}}, 4'h0, 4'h0, 16'h0000);
    tick();
    set_txn({4{6'h0B}}, {4{6'h01}}, 4'h0, 4'h0, 16'h0000);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    sb.delete();
    sig_exp = '0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (t_got) begin bad++; $display("FAIL rst_stale%0d: got output %h want none", k, t_data); end
    end
    total++; if (sig !== '0) begin bad++; $display("FAIL rst_sig: got %h want 0", sig); end
    set_txn({4{6'h2A}}, {4{6'h15}}, 4'hF, 4'hF, 16'h1234);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (t_got) begin
        total++;
        if (!t_have || t_data !== t_exp.d || t_err !== t_exp.e) begin
          bad++;
          $display("FAIL rst_recover: got %h/%b want %h/%b", t_data, t_err, t_exp.d, t_exp.e);
        end
      end
    end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rst_recover_lost: pending=%0d want 0", sb.size()); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_ops();
    test_backpressure();
    test_back_to_back();
    test_signature();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expr_lane_pipe.md
# expr_lane_pipe

Parametrised, pipelined successor to the combinational mixed-signedness expression blocks in the regression suite. Evaluates LANES independent binary expressions per transaction: operands of width W, per-operand signedness, one opcode per lane, all under Verilog context-sizing and signedness rules. The result is registered behind a two-stage valid/ready pipeline. A running XOR signature of emitted results lets benches compare long runs against the LiveHD-generated netlist.

## Interface
- W, default 6: operand width, 2..16
- LANES, default 4: independent lanes per transaction
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  transaction offered
- in_ready  out  1  transaction accepted when in_valid && in_ready
- in_a, in_b  in  LANES*W  operands; lane i at [i*W +: W]
- in_sa, in_sb  in  LANES  per-lane signed flag for a / b
- in_op  in  LANES*4  per-lane opcode
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_data  out  LANES*(W+1)  lane i at [i*(W+1) +: W+1]
- out_err  out  LANES  per-lane error flag
- sig_clr  in  1  clear signature next edge
- sig  out  LANES*(W+1)  XOR of all out_data words consumed since reset/clear

## Operation
- Result width R = W+1. Context is signed only if in_sa && in_sb; otherwise both operands are zero-extended to R, else sign-extended.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 SHL, 7 SHR (logical), 8 ASHR, 9 LT, 10 LE, 11 EQ, 12 LAND, 13 RXOR(a), 14 DIV, 15 MOD.
- Arithmetic and bitwise results are computed modulo 2^R on the extended operands.
- Shifts: the amount is b, always unsigned. ASHR fills with the sign bit only in signed context and is logical otherwise. Amount >= R gives 0, or all-ones for ASHR of a negative value.
- 9–13 produce 1 bit, zero-extended to R. Comparisons use the context signedness.
- out_err is set only by 14/15 as described under Configuration.
- sig updates on every output handshake: sig <= sig ^ out_data. sig_clr has priority and loads 0, including when it coincides with a handshake.

## Timing
- Stage S1 registers the extended operands, context flags and opcodes. Stage S2 registers out_data/out_err/out_valid.
- Latency: 2 cycles from the input handshake to out_valid when unstalled. Throughput: 1 transaction/cycle.
- S2 loads when !out_valid || out_ready. S1 advances when S2 loads. in_ready = !s1_valid || s1_advance. The combinational ready path from out_ready is permitted.
- Both stages hold their contents under stall. Maximum occupancy is 2 transactions. Order is preserved.
- Reset: in_ready=1 on the cycle after rst_n high. out_valid=0, out_data=0, out_err=0, sig=0, s1_valid=0.
- Reset mid-operation discards both in-flight transactions.

## Configuration
- EXPR_PIPE_DIV_EN defined: 14/15 compute a/b and a%b in context signedness. Signed results truncate toward zero; the MOD sign follows a. b==0 yields result 0 and out_err=1.
- Macro undefined: no divider is synthesised. 14/15 yield result 0 and out_err=1 for every b.

## Structure
- Package expr_pipe_pkg holds the opcode enum (op_e, 4 bits) and the function for result-width derivation.
- Sub-module expr_lane is a combinational single-lane evaluator parametrised by W, instantiated LANES times between S1 and S2. Pipeline registers, handshake and signature live in the top.

## Test plan
- ADD, lane 0, W=6: a=6'h3F, b=6'h01. Both signed -> 7'h00. sa=0 -> 7'h40.
- LT: a=6'h3F, b=6'h01. Both signed -> 7'h01. sa=1, sb=0 -> 7'h00 (unsigned 63<1).
- ASHR: a=6'h20, b=2. Both signed -> 7'h78. Unsigned -> 7'h08. SHL a=6'h21, b=7 -> 7'h00.
- Backpressure: out_ready=0 while in_valid is held with 3 distinct transactions. Two accepted, in_ready=0 on the third. After out_ready=1, outputs appear in order, 1/cycle.
- DIV/MOD unsigned: a=13, b=4. With macro -> 3 / 1, err=0. With b=0 -> 0, err=1. Without macro -> 0, err=1.
- Signature and reset: consume 7'h11 then 7'h05 -> sig lane 0 = 7'h14. sig_clr coincident with a third handshake -> sig=0. rst_n low with 2 in flight -> out_valid=0 next cycle and no stale output afterwards.
